// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first, one bit per clock, start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_e          state_q;
    logic [N-1:0]    a_sh_q;
    logic [N-1:0]    b_sh_q;
    logic [N-1:0]    y_sh_q;
    logic [N-1:0]    y_sh_d;
    logic [N-1:0]    y_q;
    logic            c_q;
    logic            cout_q;
    logic [CntW-1:0] cnt_q;
    logic            s;
    logic            co;
    logic            last;
`ifdef SERIAL_ADDER_OVF_EN
    logic            ovf_q;
`endif

    full_adder_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (c_q),
        .s  (s),
        .co (co)
    );

    // New sum bit enters at the MSB; after N shifts bit 0 lands in y_sh[0].
    assign y_sh_d = N'({s, y_sh_q} >> 1);
    assign last   = (cnt_q == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            y_sh_q  <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_q     <= cin;
                        y_sh_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    y_sh_q <= y_sh_d;
                    c_q    <= co;
                    if (last) begin
                        y_q     <= y_sh_d;
                        cout_q  <= co;
`ifdef SERIAL_ADDER_OVF_EN
                        // c_q is the carry into the MSB on the last bit.
                        ovf_q   <= c_q ^ co;
`endif
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign y    = y_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (N=16); covers handshake, latency and reset.
module tb_serial_adder;

    localparam int unsigned N = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [N-1:0]  y;
    logic          cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic          ovf;
`endif

    int n_cmp;
    int n_fail;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [15:0] ey;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges until done is seen; expects to be called #1 after an edge.
    task automatic wait_done(output int cyc, output logic y_moved);
        logic [N-1:0] y0;
        y0      = y;
        y_moved = 1'b0;
        cyc     = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done !== 1'b1 && y !== y0) y_moved = 1'b1;
        end
    endtask

    task automatic accept(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic run_op(input vec_t v);
        int   cyc;
        logic moved;
        accept(v.va, v.vb, v.vc);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(cyc, moved);
        chk("latency", 32'(cyc), 32'(N));
        chk("y_held_during_shift", 32'(moved), 32'd0);
        chk("y", 32'(y), 32'(v.ey));
        chk("cout", 32'(cout), 32'(v.ec));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(v.eo));
`endif
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int   cyc;
        logic moved;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0};

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // start during SHIFT must be ignored
        accept(16'h1234, 16'h1111, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, moved);
        chk("ignored_start_latency", 32'(cyc), 32'(N - 4));
        chk("ignored_start_y", 32'(y), 32'h2345);
        chk("ignored_start_cout", 32'(cout), 32'd0);

        // back-to-back: start held in the DONE cycle
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0002;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_y_held", 32'(y), 32'h2345);
        wait_done(cyc, moved);
        chk("b2b_period", 32'(cyc + 1), 32'(N + 1));
        chk("b2b_y", 32'(y), 32'h0003);
        chk("b2b_cout", 32'(cout), 32'd0);

        // asynchronous reset mid-operation at bit 7
        @(posedge clk);
        #1;
        accept(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
